// File: rtl/reg_commit_tracer.sv
// Register-commit tracer: records writes to watched registers into a
// DEPTH-entry FWFT buffer with cycle stamps, optional wrap and auto-freeze.
module reg_commit_tracer #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 16,
  parameter int          STAMP_W     = 16,
  parameter logic [31:0] WATCH_MASK  = 32'h03FF_FF00,
  parameter int          STOP_CYCLES = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     mode_wrap,
  input  logic                     wb_en,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [DATA_W-1:0]        wb_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [4:0]               rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]      FULL_CNT   = CW'(DEPTH);
  localparam bit                 STOP_EN    = (STOP_CYCLES != 0);
  localparam logic [STAMP_W-1:0] STOP_STAMP = STAMP_W'(STOP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FROZEN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic [STAMP_W-1:0]   r_stamp;

  logic [4:0]           r_mem_addr  [DEPTH];
  logic [DATA_W-1:0]    r_mem_data  [DEPTH];
  logic [DATA_W-1:0]    r_mem_pc    [DEPTH];
  logic [STAMP_W-1:0]   r_mem_stamp [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_stop;
  logic w_store;
  logic w_head_adv;
  logic w_tail_adv;
  logic w_count_inc;
  logic w_count_dec;
  logic w_ovf_set;

  // arm suppresses capture on its own edge because the buffer is being cleared.
  assign w_push = (r_state == S_CAPTURE) && wb_en && (wb_addr != 5'd0) &&
                  WATCH_MASK[wb_addr] && !arm;
  assign w_pop  = rd_valid && rd_ready;
  assign w_full = (r_count == FULL_CNT);
  assign w_stop = STOP_EN && (r_stamp == STOP_STAMP);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (arm) w_next_state = S_CAPTURE;
      S_CAPTURE: if (arm) w_next_state = S_CAPTURE;
                 else if (w_stop) w_next_state = S_FROZEN;
      S_FROZEN:  if (arm) w_next_state = S_CAPTURE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // When full, tail==head, so a push+pop writes into the slot being popped.
  always_comb begin
    w_store     = 1'b0;
    w_head_adv  = 1'b0;
    w_tail_adv  = 1'b0;
    w_count_inc = 1'b0;
    w_count_dec = 1'b0;
    w_ovf_set   = 1'b0;
    if (w_push && w_pop) begin
      w_store    = 1'b1;
      w_head_adv = 1'b1;
      w_tail_adv = 1'b1;
    end else if (w_push) begin
      if (!w_full) begin
        w_store     = 1'b1;
        w_tail_adv  = 1'b1;
        w_count_inc = 1'b1;
      end else if (mode_wrap) begin
        w_store    = 1'b1;
        w_head_adv = 1'b1;
        w_tail_adv = 1'b1;
        w_ovf_set  = 1'b1;
      end else begin
        w_ovf_set = 1'b1;
      end
    end else if (w_pop) begin
      w_head_adv  = 1'b1;
      w_count_dec = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stamp    <= '0;
    end else begin
      r_state <= w_next_state;
      if (arm) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_stamp    <= '0;
      end else begin
        if (w_head_adv)  r_head  <= r_head + PW'(1);
        if (w_tail_adv)  r_tail  <= r_tail + PW'(1);
        if (w_count_inc) r_count <= r_count + CW'(1);
        else if (w_count_dec) r_count <= r_count - CW'(1);
        if (w_ovf_set)   r_overflow <= 1'b1;
        if (r_state == S_CAPTURE) r_stamp <= r_stamp + STAMP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem_addr[r_tail]  <= wb_addr;
      r_mem_data[r_tail]  <= wb_data;
      r_mem_pc[r_tail]    <= wb_pc;
      r_mem_stamp[r_tail] <= r_stamp;
    end
  end

  // Read data is gated so an empty buffer (and reset) shows zeros.
  assign rd_valid = (r_count != '0);
  assign rd_addr  = rd_valid ? r_mem_addr[r_head]  : '0;
  assign rd_data  = rd_valid ? r_mem_data[r_head]  : '0;
  assign rd_pc    = rd_valid ? r_mem_pc[r_head]    : '0;
  assign rd_stamp = rd_valid ? r_mem_stamp[r_head] : '0;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign state    = r_state;

endmodule

// File: tb/tb_reg_commit_tracer.sv
// Bench for reg_commit_tracer: directed scenarios plus randomized traffic
// checked against a queue-based model of the trace buffer.
module tb_reg_commit_tracer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int SW    = 16;
  localparam int ENT_W = 5 + DW + DW + SW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          arm, arm_s;
  logic          mode_wrap;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data, wb_pc;
  logic          rd_ready, rd_ready_s;

  logic          rd_valid, s_rd_valid;
  logic [4:0]    rd_addr, s_rd_addr;
  logic [DW-1:0] rd_data, s_rd_data, rd_pc, s_rd_pc;
  logic [SW-1:0] rd_stamp, s_rd_stamp;
  logic [2:0]    count, s_count;
  logic          overflow, s_overflow;
  logic [1:0]    state, s_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]      mask_v;
  logic [ENT_W-1:0] exp_q[$];
  logic [1:0]       m_state;
  logic [SW-1:0]    m_stamp;
  logic             m_ovf;

  reg_commit_tracer #(.DATA_W(DW), .DEPTH(DEPTH), .STAMP_W(SW),
    .WATCH_MASK(32'h03FF_FF00), .STOP_CYCLES(0)) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .mode_wrap(mode_wrap),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_pc(rd_pc), .rd_stamp(rd_stamp), .count(count),
    .overflow(overflow), .state(state));

  reg_commit_tracer #(.DATA_W(DW), .DEPTH(DEPTH), .STAMP_W(SW),
    .WATCH_MASK(32'h03FF_FF00), .STOP_CYCLES(3)) dut_stop (
    .clock(clock), .reset_n(reset_n), .arm(arm_s), .mode_wrap(mode_wrap),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .rd_ready(rd_ready_s), .rd_valid(s_rd_valid), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .rd_pc(s_rd_pc), .rd_stamp(s_rd_stamp), .count(s_count),
    .overflow(s_overflow), .state(s_state));

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // drivers
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [DW-1:0] d, input logic [DW-1:0] pc);
    wb_en = 1'b1; wb_addr = a; wb_data = d; wb_pc = pc;
    tick();
    wb_en = 1'b0;
  endtask

  // reference model: one clock edge of the trace buffer behaviour
  task automatic model_step();
    logic [ENT_W-1:0] e;
    bit pop, push;
    if (arm) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_stamp = '0;
      m_state = 2'd1;
    end else begin
      pop  = (exp_q.size() != 0) && rd_ready;
      push = (m_state == 2'd1) && wb_en && (wb_addr != 5'd0) && mask_v[wb_addr];
      e = {wb_addr, wb_data, wb_pc, m_stamp};
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else begin
          m_ovf = 1'b1;
          if (mode_wrap) begin
            void'(exp_q.pop_front());
            exp_q.push_back(e);
          end
        end
      end
      if (m_state == 2'd1) m_stamp = m_stamp + 16'd1;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", rd_valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    n_tests++; if ({rd_addr, rd_data, rd_pc, rd_stamp} !== '0) begin n_fail++; $display("FAIL rst_rd got %h/%h/%h/%h exp 0", rd_addr, rd_data, rd_pc, rd_stamp); end
    n_tests++; if (s_state !== 2'd0) begin n_fail++; $display("FAIL rst_s_state got %0d exp 0", s_state); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_first_write();
    mode_wrap = 1'b0;
    do_arm();
    wr(5'd16, 32'h5, 32'h8);
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fw_valid got %b exp 1", rd_valid); end
    n_tests++; if (rd_addr !== 5'd16) begin n_fail++; $display("FAIL fw_addr got %0d exp 16", rd_addr); end
    n_tests++; if (rd_data !== 32'h5) begin n_fail++; $display("FAIL fw_data got %h exp 5", rd_data); end
    n_tests++; if (rd_pc !== 32'h8) begin n_fail++; $display("FAIL fw_pc got %h exp 8", rd_pc); end
    n_tests++; if (rd_stamp !== 16'd0) begin n_fail++; $display("FAIL fw_stamp got %0d exp 0", rd_stamp); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL fw_count got %0d exp 1", count); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL fw_state got %0d exp 1", state); end
  endtask

  task automatic test_filter();
    do_arm();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flt_armclr got %0d exp 0", count); end
    wr(5'd0, 32'h11, 32'h100);
    wr(5'd1, 32'h22, 32'h104);
    wr(5'd31, 32'h33, 32'h108);
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flt_count got %0d exp 0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flt_valid got %b exp 0", rd_valid); end
    rst_pulse();
    wr(5'd8, 32'h44, 32'h10c);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL flt_idle_state got %0d exp 0", state); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flt_idle_count got %0d exp 0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flt_idle_valid got %b exp 0", rd_valid); end
  endtask

  task automatic test_reset_mid();
    do_arm();
    wr(5'd8, 32'h1, 32'h0);
    wr(5'd9, 32'h2, 32'h4);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL rm_pre_count got %0d exp 2", count); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || rd_valid !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL rm_async got cnt=%0d v=%b st=%0d exp 0/0/0", count, rd_valid, state); end
    #1;
    reset_n = 1'b1;
    wr(5'd8, 32'h3, 32'h8);
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rm_post_count got %0d exp 0", count); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rm_post_state got %0d exp 0", state); end
  endtask

  task automatic test_full(input logic wrap);
    mode_wrap = wrap;
    do_arm();
    for (int i = 1; i <= 6; i++) wr(5'd8, DW'(i), DW'(i * 4));
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full%0d_count got %0d exp 4", wrap, count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full%0d_ovf got %b exp 1", wrap, overflow); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== DW'(wrap ? 3 + i : 1 + i)) begin n_fail++; $display("FAIL full%0d_pop%0d got v=%b d=%0d exp %0d", wrap, i, rd_valid, rd_data, wrap ? 3 + i : 1 + i); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    n_tests++; if (count !== 3'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL full%0d_empty got cnt=%0d v=%b exp 0/0", wrap, count, rd_valid); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full%0d_sticky got %b exp 1", wrap, overflow); end
  endtask

  task automatic test_push_pop_full();
    mode_wrap = 1'b1;
    do_arm();
    for (int i = 1; i <= 4; i++) wr(5'd17, DW'(i), DW'(i));
    wb_en = 1'b1; wb_addr = 5'd17; wb_data = 32'd9; wb_pc = 32'h90; rd_ready = 1'b1;
    n_tests++; if (rd_data !== 32'd1) begin n_fail++; $display("FAIL pp_popped got %0d exp 1", rd_data); end
    tick();
    wb_en = 1'b0; rd_ready = 1'b0;
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL pp_count got %0d exp 4", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rd_data !== DW'(i < 3 ? i + 2 : 9)) begin n_fail++; $display("FAIL pp_drain%0d got %0d exp %0d", i, rd_data, i < 3 ? i + 2 : 9); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_stop();
    rst_pulse();
    arm_s = 1'b1;
    tick();
    arm_s = 1'b0;
    for (int i = 0; i < 6; i++) wr(5'd16, DW'(100 + i), DW'(i));
    n_tests++; if (s_state !== 2'd2) begin n_fail++; $display("FAIL stop_state got %0d exp 2", s_state); end
    n_tests++; if (s_count !== 3'd3) begin n_fail++; $display("FAIL stop_count got %0d exp 3", s_count); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (s_rd_stamp !== SW'(i) || s_rd_data !== DW'(100 + i)) begin n_fail++; $display("FAIL stop_entry%0d got st=%0d d=%0d exp st=%0d d=%0d", i, s_rd_stamp, s_rd_data, i, 100 + i); end
      if (i < 2) begin
        rd_ready_s = 1'b1;
        tick();
        rd_ready_s = 1'b0;
      end
    end
    n_tests++; if (s_count !== 3'd1) begin n_fail++; $display("FAIL stop_frozen_pop got %0d exp 1", s_count); end
    rst_pulse();
    n_tests++; if (s_state !== 2'd0 || s_count !== 3'd0 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL stop_reset got st=%0d cnt=%0d v=%b exp 0/0/0", s_state, s_count, s_rd_valid); end
  endtask

  task automatic test_random(input int phase);
    logic [ENT_W-1:0] h;
    rst_pulse();
    exp_q.delete();
    m_state = 2'd0; m_stamp = '0; m_ovf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      arm       = (c == 2) || ($urandom_range(0, 59) == 0);
      mode_wrap = (phase == 2) ? 1'($urandom_range(0, 1)) : 1'(phase);
      wb_en     = 1'($urandom_range(0, 3) != 0);
      wb_addr   = 5'($urandom_range(0, 31));
      wb_data   = $urandom();
      wb_pc     = $urandom();
      rd_ready  = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      n_tests++; if (state !== m_state) begin n_fail++; $display("FAIL rnd%0d_state c=%0d got %0d exp %0d", phase, c, state, m_state); end
      n_tests++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd%0d_count c=%0d got %0d exp %0d", phase, c, count, exp_q.size()); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd%0d_ovf c=%0d got %b exp %b", phase, c, overflow, m_ovf); end
      n_tests++; if (rd_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd%0d_valid c=%0d got %b", phase, c, rd_valid); end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        n_tests++; if ({rd_addr, rd_data, rd_pc, rd_stamp} !== h) begin n_fail++; $display("FAIL rnd%0d_head c=%0d got %h/%h/%h/%h exp %h", phase, c, rd_addr, rd_data, rd_pc, rd_stamp, h); end
      end
    end
    arm = 1'b0; wb_en = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    mask_v = 32'h03FF_FF00;
    reset_n = 1'b0;
    arm = 1'b0; arm_s = 1'b0; mode_wrap = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    rd_ready = 1'b0; rd_ready_s = 1'b0;
    test_reset();
    test_first_write();
    test_filter();
    test_reset_mid();
    test_full(1'b1);
    test_full(1'b0);
    test_push_pop_full();
    test_stop();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
